// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one block_width slice per clock,
// LSB slice first, with the borrow carried between cycles in a register.
// Operands enter on a valid/ready handshake; the result leaves on another.
module block_serial_subtractor #(
    parameter int block_width = 4,
    parameter int width       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             overflow
);

    localparam int block_num = width / block_width;
    localparam int cnt_w     = (block_num > 1) ? $clog2(block_num) : 1;
    localparam logic [cnt_w-1:0] last_slice = cnt_w'(block_num - 1);

    // A width that is not a whole number of slices cannot be processed.
    if (width % block_width != 0) begin : g_bad_block_width
        $error("block_width must divide width exactly");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     a_q, a_d;
    logic [width-1:0]     b_q, b_d;
    logic                 borrow_q, borrow_d;
    logic [cnt_w-1:0]     cnt_q, cnt_d;
    logic [width-1:0]     diff_q, diff_d;
    logic                 bout_q, bout_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;

    int                   slice_lo;
    logic [block_width:0] slice_res;

    // One extra bit of headroom turns the slice subtraction's MSB into the borrow.
    assign slice_lo  = int'(cnt_q) * block_width;
    assign slice_res = {1'b0, a_q[slice_lo +: block_width]}
                     - {1'b0, b_q[slice_lo +: block_width]}
                     - {{block_width{1'b0}}, borrow_q};

    // NOTE: in_ready is gated by rst directly so it drops the instant reset
    // asserts, not at the next edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

    // Next-state and datapath update for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        // NOTE: every target gets its hold value first so no path infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                diff_d[slice_lo +: block_width] = slice_res[block_width-1:0];
                borrow_d = slice_res[block_width];
                cnt_d    = cnt_q + cnt_w'(1);
                if (cnt_q == last_slice) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    bout_d  = slice_res[block_width];
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[width-1] != b_q[width-1])
                           && (diff_d[width-1] != a_q[width-1]);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Self-checking bench for block_serial_subtractor: a driver issues operations
// and pushes model results to a scoreboard; a monitor pops and compares them
// whenever the DUT completes an output handshake.
module tb_block_serial_subtractor;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int NB = W / BW;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         bin       = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    block_serial_subtractor #(.block_width(BW), .width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference result from whole-word arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
        exp_t           e;
        longint unsigned lx, ly, lb;
        lx     = longint'(x);
        ly     = longint'(y);
        lb     = longint'(bi);
        e.diff = W'((lx - ly - lb) % (64'd1 << W));
        e.bout = (lx < ly + lb);
        e.zero = (e.diff == '0);
        e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare each result as it is handed over.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("diff", 64'(diff), 64'(e.diff));
                check("bout", 64'(bout), 64'(e.bout));
                check("zero", 64'(zero), 64'(e.zero));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic bi, input bit push);
        int g = 0;
        while (in_ready !== 1'b1 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        a        = x;
        b        = y;
        bin      = bi;
        in_valid = 1'b1;
        if (push) sb.push_back(model(x, y, bi));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom);
    endtask

    task automatic wait_valid();
        int c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (out_valid !== 1'b1 && c < 50);
        check("latency", 64'(c), 64'(NB));
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bi, input int stall);
        out_ready = (stall == 0);
        start_op(x, y, bi, 1'b1);
        wait_valid();
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e_bp;

        // Reset state, with in_valid asserted to show it is ignored.
        #1 rst = 1'b1;
        in_valid = 1'b1;
        a = 32'd55;
        b = 32'd11;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_flags", 64'({bout, zero, overflow}), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        do_op(32'd10, 32'd3, 1'b0, 0);
        do_op(32'd3, 32'd10, 1'b0, 0);
        do_op(32'd0, 32'd0, 1'b1, 0);
        do_op(32'h8000_0000, 32'd1, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'd5, 32'd4, 1'b1, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);

        // Backpressure in DONE while new operands are offered.
        out_ready = 1'b0;
        e_bp = model(32'h1234_5678, 32'h0000_5679, 1'b0);
        start_op(32'h1234_5678, 32'h0000_5679, 1'b0, 1'b1);
        wait_valid();
        repeat (5) begin
            a        = $urandom;
            b        = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_diff", 64'(diff), 64'(e_bp.diff));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        do_op(32'd7, 32'd9, 1'b1, 0);

        // Reset during the 4th BUSY cycle.
        start_op(32'hABCD_EF01, 32'h1234_5678, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_diff", 64'(diff), 64'd0);
        check("abort_bout", 64'(bout), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_ready", 64'(in_ready), 64'd1);
        do_op(32'd100, 32'd1, 1'b0, 0);

        // Randomised operations with some near-equal operands and stalls.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x + 32'd1;
                2:       y = {~x[W-1], x[W-2:0]};
                default: y = $urandom;
            endcase
            do_op(x, y, 1'($urandom), int'($urandom_range(0, 2)));
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/block_serial_subtractor.md
Name: block_serial_subtractor

Overview:
Multi-cycle subtractor, the inverse of the lookahead adder in the arithmetic library. It computes diff = a - b - bin one block_width slice per clock, LSB slice first, and carries the borrow between cycles in a register. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. It is used where area matters more than latency, for example inside sequential divider and comparator datapaths.

Parameters:
- block_width, 4, bits processed per cycle; must divide width exactly, otherwise elaboration fails.
- width, 32, operand and result width in bits; block_num = width / block_width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  width  minuend.
- b  input  width  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result registers are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  width  a - b - bin, modulo 2^width.
- bout  output  1  borrow out; 1 iff unsigned a < b + bin.
- zero  output  1  diff == 0.
- overflow  output  1  two's-complement overflow of the subtraction.

Behaviour:
- FSM states: IDLE, BUSY, DONE. A slice counter, 0..block_num-1, runs during BUSY.
- While rst is high: state is IDLE, out_valid=0, diff=0, bout=0, zero=0, overflow=0, and in_ready is forced to 0. Internal operand registers, borrow register and counter are cleared.
- in_ready = (state == IDLE) and not rst.
- IDLE:
  - Accept when in_valid and in_ready are both high at a rising edge.
  - On accept, latch a, b, bin into the borrow register; set counter to 0; go to BUSY.
- BUSY, each cycle:
  - Slice i = bits [(i+1)*block_width-1 : i*block_width].
  - Compute a_slice - b_slice - borrow with block_width+1-bit arithmetic.
  - Write the result bits into diff slice i and update the borrow register.
  - Increment the counter.
  - On the cycle that handles slice block_num-1, go to DONE, and register bout, zero and overflow in that same edge.
- Flags:
  - zero is evaluated on the full completed diff.
  - overflow = (a[width-1] != b[width-1]) and (diff[width-1] != a[width-1]), using the latched operands.
  - bin does not enter the overflow formula.
- Latency: accept at edge k gives out_valid=1 from edge k+block_num. Throughput is one operation per block_num+2 cycles at best.
- DONE:
  - out_valid=1 and all result outputs are held stable.
  - When out_ready=1 at an edge, clear out_valid and return to IDLE. in_ready rises after that edge.
- Output values:
  - diff, bout, zero and overflow hold the last completed result through IDLE until the next operation reaches DONE.
  - While BUSY they may show partial slices; their values are meaningful only when out_valid=1.
- No overlap: in_valid is ignored in BUSY and DONE, and operands must not be sampled in those states.
- in_valid with no acceptance (rst high, or not IDLE) has no effect.
- Reset mid-operation: rst in BUSY or DONE aborts immediately. No result is produced, and the first operation after reset release is computed correctly.
- block_width == width is legal: block_num=1 and latency is 1 cycle.
- block_width=1 is legal: a bit-serial subtractor with latency width.

Test Plan:
All scenarios use width=32, block_width=4, so block_num=8.
1. a=10, b=3, bin=0 → diff=0x00000007, bout=0, zero=0, overflow=0. out_valid rises exactly 8 cycles after the accept edge.
2. a=3, b=10, bin=0 → diff=0xFFFFFFF9, bout=1, overflow=0. Then a=0, b=0, bin=1 → diff=0xFFFFFFFF, bout=1 (borrow ripples through all 8 slices).
3. a=0x80000000, b=1 → diff=0x7FFFFFFF, overflow=1, bout=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, overflow=1, bout=1.
4. a=5, b=4, bin=1 → diff=0, zero=1, bout=0, overflow=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → out_valid and diff stay stable, in_ready=0, and the new operands are not taken. Then raise out_ready → out_valid falls and in_ready=1 on the next cycle. The next operation is correct.
6. Reset: assert rst during the 4th BUSY cycle → out_valid=0 and in_ready=0 immediately without waiting for a clock edge; diff=0, bout=0. After release, in_ready=1 and a=100, b=1 → diff=99.
